// File: rtl/pc_sequencer_pkg.sv
// Shared miniRISC fetch definitions: FSM state encodings, datapath widths and
// default instruction step.
package pc_sequencer_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned OFF_W           = 16;
  localparam int unsigned STATE_W         = 2;
  localparam int unsigned DEFAULT_PC_STEP = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } pc_state_e;

  // Word offset to byte offset, sign-extended to the address width.
  function automatic logic [XLEN-1:0] word_off_to_bytes(input logic [OFF_W-1:0] off);
    return {{(XLEN-OFF_W-2){off[OFF_W-1]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_pc_adder.sv
// Address arithmetic for the fetch sequencer: sequential, PC-relative and
// link (return) addresses.
module pc_adder
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned PC_STEP = DEFAULT_PC_STEP
) (
  input  logic [XLEN-1:0]  pc,
  input  logic [OFF_W-1:0] br_offset,
  output logic [XLEN-1:0]  seq_pc,
  output logic [XLEN-1:0]  rel_pc,
  output logic [XLEN-1:0]  link_addr
);

  assign seq_pc    = pc + XLEN'(PC_STEP);
  // Relative branches are measured from the following instruction.
  assign rel_pc    = seq_pc + word_off_to_bytes(br_offset);
  assign link_addr = seq_pc;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALTED fetch control with sequential
// advance, stall, relative and absolute branches.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned PC_STEP      = DEFAULT_PC_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  input  logic        br_taken,
  input  logic        br_mode,
  input  logic [15:0] br_offset,
  input  logic [31:0] br_target,
  input  logic        halt,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic [31:0] link_addr,
  output logic        align_err,
  output logic [1:0]  state
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] seq_pc, rel_pc;
  logic            valid_q;
  logic            err_q, err_set;

  pc_adder #(.PC_STEP(PC_STEP)) u_adder (
    .pc        (pc_q),
    .br_offset (br_offset),
    .seq_pc    (seq_pc),
    .rel_pc    (rel_pc),
    .link_addr (link_addr)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; the unused encoding falls back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_RUN;
      ST_RUN:    if (halt)  state_d = ST_HALTED;
      ST_HALTED: if (start) state_d = ST_RUN;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next-PC selection: halt > branch > stall > sequential
  always_comb begin
    pc_d    = pc_q;
    err_set = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (halt) begin
          pc_d = pc_q;
        end else if (br_taken) begin
          if (br_mode) begin
            pc_d    = {br_target[31:2], 2'b00};
            err_set = |br_target[1:0];
          end else begin
            pc_d = rel_pc;
          end
        end else if (!stall) begin
          pc_d = seq_pc;
        end
      end
      ST_HALTED: if (start) pc_d = seq_pc;
      default:   pc_d = pc_q;
    endcase
  end

  // Datapath registers; pc_valid tracks the state being entered
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= (state_d == ST_RUN);
      err_q   <= err_q | err_set;
    end
  end

  assign pc        = pc_q;
  assign pc_valid  = valid_q;
  assign align_err = err_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed bench for pc_sequencer against a rule-level model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, stall, br_taken, br_mode, halt;
  logic [15:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] pc, link_addr;
  logic        pc_valid, align_err;
  logic [1:0]  state;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: 0 idle, 1 running, 2 halted
  longint m_pc;
  int     m_mode;
  bit     m_err;

  localparam longint MASK = 64'h0000_0000_FFFF_FFFF;

  pc_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_mode   (br_mode),
    .br_offset (br_offset),
    .br_target (br_target),
    .halt      (halt),
    .pc        (pc),
    .pc_valid  (pc_valid),
    .link_addr (link_addr),
    .align_err (align_err),
    .state     (state)
  );

  always #5 clk = ~clk;

  function automatic logic [67:0] model_vec();
    logic [31:0] p, l;
    logic [1:0]  s;
    p = 32'(m_pc);
    l = 32'((m_pc + 4) & MASK);
    s = 2'(m_mode);
    return {p, l, (m_mode == 1), m_err, s};
  endfunction

  // Drive one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic cyc(input bit r, input bit s, input bit stl, input bit bt,
                     input bit bm, input logic [15:0] off, input logic [31:0] tgt,
                     input bit h);
    rst = r; start = s; stall = stl; br_taken = bt; br_mode = bm;
    br_offset = off; br_target = tgt; halt = h;
    if (!r) begin
      m_pc = 0; m_mode = 0; m_err = 0;
    end else if (m_mode == 0) begin
      if (s) m_mode = 1;
    end else if (m_mode == 1) begin
      if (h) m_mode = 2;
      else if (bt && bm) begin
        m_pc = longint'(tgt) - (longint'(tgt) % 4);
        if (tgt % 4 != 0) m_err = 1;
      end else if (bt) m_pc = (m_pc + 4 + 4 * longint'($signed(off))) & MASK;
      else if (!stl) m_pc = (m_pc + 4) & MASK;
    end else if (s) begin
      m_mode = 1;
      m_pc = (m_pc + 4) & MASK;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 0, 16'h0, 32'h0, 0);
  endtask

  task automatic jump(input logic [31:0] tgt);
    cyc(1, 0, 0, 1, 1, 16'h0, tgt, 0);
  endtask

  task automatic test_reset();
    cyc(0, 1, 1, 1, 1, 16'h1234, 32'h55, 1);
    cyc(0, 1, 0, 1, 0, 16'h7, 32'h0, 0);
    n_cmp++;
    if ({pc, pc_valid, align_err, state} !== {32'h0, 1'b0, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset: got pc=%h v=%b e=%b st=%0d want pc=0 v=0 e=0 st=0",
               pc, pc_valid, align_err, state);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    cyc(1, 1, 0, 0, 0, 16'h0, 32'h0, 0);
    n_cmp++;
    if ({pc, pc_valid, state} !== {32'h0, 1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL start: got pc=%h v=%b st=%0d want pc=0 v=1 st=1", pc, pc_valid, state);
    end
    for (int i = 1; i <= 4; i++) begin
      idle();
      exp_pc = 32'(i * 4);
      n_cmp++;
      if (pc !== exp_pc || link_addr !== exp_pc + 32'd4) begin
        n_fail++;
        $display("FAIL seq[%0d]: got pc=%h link=%h want pc=%h", i, pc, link_addr, exp_pc);
      end
    end
  endtask

  task automatic test_wrap();
    jump(32'hFFFF_FFFC);
    idle();
    n_cmp++;
    if ({pc, align_err} !== {32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL seq_wrap: got pc=%h e=%b want pc=0 e=0", pc, align_err);
    end
  endtask

  task automatic test_rel_branch();
    jump(32'h100);
    cyc(1, 0, 0, 1, 0, 16'hFFFE, 32'h0, 0);
    n_cmp++;
    if (pc !== 32'h0000_00FC) begin
      n_fail++;
      $display("FAIL rel_back: got pc=%h want 000000fc", pc);
    end
    jump(32'hFFFF_FFF0);
    cyc(1, 0, 0, 1, 0, 16'h7FFF, 32'h0, 0);
    n_cmp++;
    if (pc !== 32'h0001_FFF0) begin
      n_fail++;
      $display("FAIL rel_wrap: got pc=%h want 0001fff0", pc);
    end
  endtask

  task automatic test_abs_branch();
    jump(32'h20);
    jump(32'h203);
    n_cmp++;
    if ({pc, align_err} !== {32'h200, 1'b1}) begin
      n_fail++;
      $display("FAIL abs_misalign: got pc=%h e=%b want pc=00000200 e=1", pc, align_err);
    end
    repeat (10) idle();
    n_cmp++;
    if (align_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got e=%b want 1", align_err);
    end
  endtask

  task automatic test_halt();
    jump(32'h40);
    cyc(1, 0, 1, 1, 0, 16'h10, 32'h0, 1);
    n_cmp++;
    if ({pc, pc_valid, state} !== {32'h40, 1'b0, 2'd2}) begin
      n_fail++;
      $display("FAIL halt: got pc=%h v=%b st=%0d want pc=40 v=0 st=2", pc, pc_valid, state);
    end
    repeat (3) cyc(1, 0, 0, 1, 0, 16'h10, 32'h0, 0);
    n_cmp++;
    if ({pc, state} !== {32'h40, 2'd2}) begin
      n_fail++;
      $display("FAIL halt_hold: got pc=%h st=%0d want pc=40 st=2", pc, state);
    end
    cyc(1, 1, 0, 0, 0, 16'h0, 32'h0, 0);
    n_cmp++;
    if ({pc, pc_valid, state} !== {32'h44, 1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL resume: got pc=%h v=%b st=%0d want pc=44 v=1 st=1", pc, pc_valid, state);
    end
  endtask

  task automatic test_stall();
    jump(32'h8);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 1, 0, 0, 16'h0, 32'h0, 0);
      n_cmp++;
      if (pc !== 32'h8) begin
        n_fail++;
        $display("FAIL stall[%0d]: got pc=%h want 00000008", i, pc);
      end
    end
    cyc(1, 0, 1, 1, 1, 16'h0, 32'h80, 0);
    n_cmp++;
    if (pc !== 32'h80) begin
      n_fail++;
      $display("FAIL stall_branch: got pc=%h want 00000080", pc);
    end
  endtask

  task automatic test_reset_mid_branch();
    jump(32'h300);
    cyc(0, 0, 0, 1, 0, 16'h0040, 32'h0, 0);
    n_cmp++;
    if ({pc, state, align_err, pc_valid} !== {32'h0, 2'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_branch: got pc=%h st=%0d e=%b v=%b want pc=0 st=0 e=0 v=0",
               pc, state, align_err, pc_valid);
    end
    cyc(1, 1, 0, 0, 0, 16'h0, 32'h0, 0);
  endtask

  task automatic test_random();
    logic [67:0] exp;
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 39) != 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 1) == 1, 16'($urandom), $urandom,
          $urandom_range(0, 15) == 0);
      exp = model_vec();
      n_cmp++;
      if ({pc, link_addr, pc_valid, align_err, state} !== exp) begin
        n_fail++;
        $display("FAIL random[%0d]: got pc=%h link=%h v=%b e=%b st=%0d want pc=%h link=%h v=%b e=%b st=%0d",
                 i, pc, link_addr, pc_valid, align_err, state,
                 exp[67:36], exp[35:4], exp[3], exp[2], exp[1:0]);
      end
    end
  endtask

  initial begin
    m_pc = 0; m_mode = 0; m_err = 0;
    rst = 1'b0; start = 1'b0; stall = 1'b0; br_taken = 1'b0; br_mode = 1'b0;
    br_offset = 16'h0; br_target = 32'h0; halt = 1'b0;
    test_reset();
    test_sequential();
    test_wrap();
    test_rel_branch();
    test_abs_branch();
    test_halt();
    test_stall();
    test_reset_mid_branch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
